// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the registered round-robin stream multiplexer.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int unsigned wrap_idx(input int unsigned idx, input int unsigned n);
        return idx % n;
    endfunction

endpackage

// File: rtl/stream_mux_rr_pick.sv
// Combinational rotating priority picker: first set request at or after start, wrapping modulo N.
module rr_pick
    import stream_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] start,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            idx = SEL_W'(wrap_idx(32'(start) + 32'(i), 32'(N)));
            if (!grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer with fixed-select or round-robin arbitration
// feeding a single output register.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_ch,
    output logic             out_valid,
    input  logic             out_ready
);

    // Handshake: a beat moves on any edge where valid && ready are both high; valid
    // never waits on ready, and a producer may not retract a beat until it is taken.

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] rr_start;
    logic [N-1:0]     rr_grant;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_any;

    logic             sel_ok;
    logic             fixed_any;
    logic [N-1:0]     fixed_grant;

    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic [N-1:0]     grant_onehot;
    logic [W-1:0]     grant_data;
    logic             load_en;
    logic             take;

    assign rr_start = SEL_W'(wrap_idx(32'(ptr) + 32'd1, 32'(N)));

    rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
        .req       (in_valid),
        .start     (rr_start),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .grant_any (rr_any)
    );

    // An out-of-range sel simply grants nobody.
    assign sel_ok    = 32'(sel) < 32'(N);
    assign fixed_any = sel_ok && in_valid[sel];

    always_comb begin
        fixed_grant = '0;
        for (int c = 0; c < N; c++) begin
            fixed_grant[c] = fixed_any && (sel == SEL_W'(c));
        end
    end

    always_comb begin
        grant_valid  = fixed_any;
        grant_idx    = sel;
        grant_onehot = fixed_grant;
        if (mode == MODE_RR) begin
            grant_valid  = rr_any;
            grant_idx    = rr_idx;
            grant_onehot = rr_grant;
        end
    end

    always_comb begin
        grant_data = '0;
        for (int c = 0; c < N; c++) begin
            if (grant_idx == SEL_W'(c)) begin
                grant_data = in_data[c*W +: W];
            end
        end
    end

    assign load_en  = !out_valid || out_ready;
    assign take     = !rst && load_en && grant_valid;
    assign in_ready = take ? grant_onehot : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SEL_W'(N - 1);
        end else if (load_en) begin
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_ch    <= grant_idx;
                ptr       <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: driver pushes expected beats, a monitor pops them
// as the output stream delivers them.
module tb_stream_mux_rr;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;
    logic        out_ready3;

    logic [7:0]  data_tbl [4];
    logic [9:0]  exp_q [$];
    int          tests;
    int          fails;

    stream_mux_rr #(.N(4), .W(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    stream_mux_rr #(.N(3), .W(8)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .mode      (mode3),
        .sel       (sel3),
        .out_data  (out_data3),
        .out_ch    (out_ch3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, failed=%0d", fails);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_data();
        in_data = {data_tbl[3], data_tbl[2], data_tbl[1], data_tbl[0]};
    endtask

    task automatic step(input logic [3:0] v, input logic m, input logic [1:0] s,
                        input logic ordy, input logic [3:0] exp_rdy);
        in_valid  = v;
        mode      = m;
        sel       = s;
        out_ready = ordy;
        apply_data();
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        for (int c = 0; c < 4; c++) begin
            if (exp_rdy[c]) exp_q.push_back({2'(c), data_tbl[c]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ordy);
        rst       = 1'b1;
        out_ready = ordy;
        exp_q.delete();
        @(negedge clk);
        check("in_ready_in_reset", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_ch", 32'(out_ch), 32'h0);
    endtask

    // Monitor: every accepted output beat must match the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got ch=%0d data=0x%0h, expected none",
                             out_ch, out_data);
                end else begin
                    check("out_beat", 32'({out_ch, out_data}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        data_tbl[0] = 8'h11;
        data_tbl[1] = 8'h22;
        data_tbl[2] = 8'h33;
        data_tbl[3] = 8'h44;
        apply_data();
        in_valid   = 4'b1111;
        mode       = 1'b0;
        sel        = 2'd2;
        out_ready  = 1'b1;
        in_data3   = 24'h332211;
        in_valid3  = 3'b111;
        mode3      = 1'b0;
        sel3       = 2'd1;
        out_ready3 = 1'b1;

        // Reset with every channel valid: nothing may be granted.
        do_reset(1'b1);

        // Fixed select on channel 2.
        for (int k = 0; k < 4; k++) step(4'b1111, 1'b0, 2'd2, 1'b1, 4'b0100);
        check("n3_out_valid", 32'(out_valid3), 32'h1);
        check("n3_out_ch", 32'(out_ch3), 32'h1);
        check("n3_out_data", 32'(out_data3), 32'h22);

        // Selected channel not valid; on N=3, sel=3 is out of range.
        sel3 = 2'd3;
        step(4'b1011, 1'b0, 2'd2, 1'b1, 4'b0000);
        check("fixed_idle_out_valid", 32'(out_valid), 32'h0);
        check("n3_in_ready", 32'(in_ready3), 32'h0);
        check("n3_idle_out_valid", 32'(out_valid3), 32'h0);

        // Round robin with all channels active rotates from channel 0.
        do_reset(1'b0);
        data_tbl[0] = 8'ha1;
        data_tbl[1] = 8'hb2;
        data_tbl[2] = 8'hc3;
        data_tbl[3] = 8'hd4;
        step(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001);
        step(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0010);
        step(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0100);
        step(4'b1111, 1'b1, 2'd0, 1'b1, 4'b1000);
        step(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001);
        step(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0010);

        // Sparse requesters, then channel 3 goes quiet.
        do_reset(1'b0);
        step(4'b1010, 1'b1, 2'd0, 1'b1, 4'b0010);
        step(4'b1010, 1'b1, 2'd0, 1'b1, 4'b1000);
        step(4'b0010, 1'b1, 2'd0, 1'b1, 4'b0010);
        step(4'b0010, 1'b1, 2'd0, 1'b1, 4'b0010);

        // Backpressure: output holds while input data changes underneath it.
        step(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0100);
        data_tbl[2] = 8'h5a;
        for (int k = 0; k < 3; k++) begin
            step(4'b1111, 1'b1, 2'd0, 1'b0, 4'b0000);
            check("stall_out_valid", 32'(out_valid), 32'h1);
            check("stall_out_ch", 32'(out_ch), 32'h2);
            check("stall_out_data", 32'(out_data), 32'hc3);
        end
        step(4'b1111, 1'b1, 2'd0, 1'b1, 4'b1000);
        check("no_bubble_out_valid", 32'(out_valid), 32'h1);
        check("no_bubble_out_ch", 32'(out_ch), 32'h3);

        // Fixed-mode grant moves ptr, so round robin resumes after channel 0.
        step(4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001);
        step(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0010);

        // Reset while a beat is pending and another would transfer.
        in_valid = 4'b1111;
        mode     = 1'b1;
        do_reset(1'b1);
        step(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001);

        // Drain.
        step(4'b0000, 1'b1, 2'd0, 1'b1, 4'b0000);
        @(negedge clk);
        check("drain_out_valid", 32'(out_valid), 32'h0);
        check("exp_q_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit registered stream multiplexer: the clocked successor to the team's combinational 2:1/8:1/16:1 muxes.
- Selects one of N valid/ready input channels into a single registered output stream.
- Two select modes: externally driven fixed select, or fair round-robin arbitration.
- Sits between multiple producers and one shared consumer; full throughput of one transfer per cycle.

## Interface
Parameters:
- N, 4, number of input channels (legal 2..16)
- W, 8, data width per channel (legal 1..64)
- SEL_W, $clog2(N), select/channel-index width (derived; not overridden)

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N*W  channel c occupies bits [c*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; at most one bit high per cycle.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- out_data  output  W  registered selected data.
- out_ch  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.

## Operation
- load_en = !out_valid || out_ready (output register empty or being drained this cycle).
- Grant, combinational:
  - Fixed mode: grant sel if sel < N and in_valid[sel]; otherwise no grant. in_valid of other channels is ignored.
  - Round-robin mode: search channels ptr+1, ptr+2, … wrapping modulo N; grant the first with in_valid high; no grant if none valid.
- in_ready[g] = load_en && grant_valid, for granted g only; all other in_ready bits are 0.
- Transfer on channel g (in_valid[g] && in_ready[g] at the edge):
  - out_data <= in_data[g]
  - out_ch <= g
  - out_valid <= 1
  - ptr <= g (ptr updates in both modes)
- load_en with no grant: out_valid <= 0. out_data/out_ch hold their values.
- !load_en (out_valid && !out_ready): all outputs hold; no input is accepted.
- Mode or sel change takes effect on the same cycle's grant. ptr is retained across mode changes.
- Round-robin with a single active channel: that channel is granted every cycle.
- Round-robin with all N channels active: grants rotate 0,1,…,N-1,0 after reset.
- Not a FIFO; no storage beyond the one output register.

## Timing
- Latency: input handshake at edge k, so out_valid/out_data valid after edge k (1 cycle).
- Throughput: one beat per cycle while out_ready is held high.
- in_ready depends combinationally on out_ready, out_valid, in_valid, mode, sel and ptr. No combinational path from in_data to any output.
- Reset (rst high at an edge) wins over any simultaneous transfer:
  - out_valid=0, out_data=0, out_ch=0
  - ptr=N-1, so the first round-robin search starts at channel 0.
- in_ready is 0 during the reset cycle.
- Reset mid-operation: a pending output beat is discarded, not delivered.
- Simultaneous drain and load: out_valid stays 1 and the new data replaces the old on the same edge (back-to-back, no bubble).

## Structure
- Package stream_mux_pkg:
  - MODE_FIXED = 1'b0 and MODE_RR = 1'b1 constants
  - function for the modulo-N index wrap
- Sub-module rr_pick: N-bit request vector plus start index in; one-hot grant, grant index and any-grant out; purely combinational.
- Top level holds the output register, ptr register, and the fixed/RR grant mux.

## Test plan
- Fixed mode, N=4, W=8, in_data = {8'h44,8'h33,8'h22,8'h11}, all valid, sel=2, out_ready=1:
  - out_data=8'h33, out_ch=2 every cycle from the cycle after reset release
  - in_ready=4'b0100
- Fixed mode, sel=2, in_valid=4'b1011: in_ready=0; out_valid drops to 0 one cycle later. Repeat with N=3, sel=3: same response.
- RR mode, all valid, out_ready=1: out_ch sequence 0,1,2,3,0,1 on consecutive cycles.
- RR mode, in_valid=4'b1010, then ch3 drops after its grant: out_ch sequence 1,3,1,1.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1:
  - out_data/out_ch stable; all in_ready=0
  - on out_ready=1, the next beat loads on the same edge with no bubble.
- Reset mid-stream: assert rst while out_valid=1 and a transfer is in progress:
  - next cycle out_valid=0, out_data=0, out_ch=0
  - first RR grant after release is channel 0.
